// File: rtl/eth_pkg.sv
// Shared constants and types for the Ethernet UDP transmit/receive path.
package eth_pkg;

    localparam logic [15:0] ETH_TYPE_IPV4   = 16'h0800;
    localparam logic [7:0]  IP_PROTO_UDP    = 8'h11;
    localparam logic [31:0] TXC_FLAG_WORD   = 32'hA000_0000;
    localparam int          HDR_BYTES       = 42;
    localparam int          MAX_UDP_PAYLOAD = 1472;
    localparam int          TXC_WORDS       = 6;
    // The last two header bytes (UDP checksum) ride in the first payload word.
    localparam int          HDR_WORDS       = (HDR_BYTES - 2) / 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CTRL,
        ST_HDR,
        ST_PAY,
        ST_TAIL
    } tx_state_t;

    function automatic logic len_valid(input logic [15:0] len);
        return (len[1:0] == 2'b00) && (len >= 16'd4) && (len <= 16'(MAX_UDP_PAYLOAD));
    endfunction

endpackage

// File: rtl/eth_udp_tx_if.sv
// Request, payload, control and frame streams of the UDP transmit framer.
interface eth_udp_tx_if;
    // Every stream moves one beat on a cycle where tvalid and tready are both high;
    // a source never drops valid or changes data/keep/last while stalled.
    logic        tx_req_valid;
    logic        tx_req_ready;
    logic [15:0] tx_payload_len;

    logic [31:0] data_tdata;
    logic [3:0]  data_tkeep;
    logic        data_tlast;
    logic        data_tvalid;
    logic        data_tready;

    logic [31:0] eth_txc_tdata;
    logic [3:0]  eth_txc_tkeep;
    logic        eth_txc_tlast;
    logic        eth_txc_tvalid;
    logic        eth_txc_tready;

    logic [31:0] eth_txd_tdata;
    logic [3:0]  eth_txd_tkeep;
    logic        eth_txd_tlast;
    logic        eth_txd_tvalid;
    logic        eth_txd_tready;

    logic        err;

    modport slave (
        input  tx_req_valid, tx_payload_len,
        input  data_tdata, data_tkeep, data_tlast, data_tvalid,
        input  eth_txc_tready, eth_txd_tready,
        output tx_req_ready, data_tready,
        output eth_txc_tdata, eth_txc_tkeep, eth_txc_tlast, eth_txc_tvalid,
        output eth_txd_tdata, eth_txd_tkeep, eth_txd_tlast, eth_txd_tvalid,
        output err
    );

    modport master (
        output tx_req_valid, tx_payload_len,
        output data_tdata, data_tkeep, data_tlast, data_tvalid,
        output eth_txc_tready, eth_txd_tready,
        input  tx_req_ready, data_tready,
        input  eth_txc_tdata, eth_txc_tkeep, eth_txc_tlast, eth_txc_tvalid,
        input  eth_txd_tdata, eth_txd_tkeep, eth_txd_tlast, eth_txd_tvalid,
        input  err
    );

endinterface

// File: rtl/eth_ip_csum.sv
// IPv4 header checksum over nine 16-bit words: one's-complement sum, fold, invert.
module eth_ip_csum (
    input  logic [8:0][15:0] words,
    output logic [15:0]      csum
);

    logic [19:0] sum;
    logic [16:0] fold1;
    logic [15:0] fold2;

    always_comb begin
        sum = '0;
        for (int i = 0; i < 9; i++) begin
            sum = sum + {4'h0, words[i]};
        end
        // Second fold cannot carry: a carry from the first leaves the low half small.
        fold1 = {1'b0, sum[15:0]} + {13'h0, sum[19:16]};
        fold2 = fold1[15:0] + {15'h0, fold1[16]};
        csum  = ~fold2;
    end

endmodule

// File: rtl/eth_udp_tx.sv
// UDP/IPv4 transmit framer: control frame on eth_txc, then header + realigned
// payload on eth_txd, with header checksum and per-frame identification.
module eth_udp_tx
    import eth_pkg::*;
#(
    parameter logic [47:0] DST_MAC  = 48'h02_00_00_00_00_00,
    parameter logic [47:0] SRC_MAC  = 48'h01_00_00_00_00_00,
    parameter logic [31:0] SRC_IP   = 32'hC0A8010A,
    parameter logic [31:0] DST_IP   = 32'hC0A80101,
    parameter logic [15:0] SRC_PORT = 16'd5000,
    parameter logic [15:0] DST_PORT = 16'd5001,
    parameter logic [7:0]  TTL      = 8'd64
) (
    input  logic        data_aclk,
    input  logic        data_aresetn,
    eth_udp_tx_if.slave bus,
    output tx_state_t   dbg_state
);

    tx_state_t   state, state_n;
    logic [15:0] len_r, ident, hold, csum_r, csum_c, tot_len, udp_len;
    logic [8:0]  cnt, n_words;
    logic        pay_last, req_hs, txc_hs, txd_hs, err_c;
    logic [7:0]  hb [40];
    logic [31:0] hw [HDR_WORDS];
    logic        unused_tkeep;

    assign unused_tkeep = ^bus.data_tkeep;
    assign tot_len      = 16'd28 + len_r;
    assign udp_len      = 16'd8 + len_r;
    assign n_words      = len_r[10:2];
    assign pay_last     = (cnt == n_words - 9'd1);
    assign dbg_state    = state;
    assign bus.err      = err_c;

    eth_ip_csum u_csum (
        .words ({16'h4500, tot_len, ident, 16'h4000, {TTL, IP_PROTO_UDP},
                 SRC_IP[31:16], SRC_IP[15:0], DST_IP[31:16], DST_IP[15:0]}),
        .csum  (csum_c)
    );

    // Header bytes in wire order, packed four per word with byte 0 in [7:0].
    always_comb begin
        for (int i = 0; i < 6; i++) begin
            hb[i]     = DST_MAC[8*(5-i) +: 8];
            hb[6 + i] = SRC_MAC[8*(5-i) +: 8];
        end
        hb[12] = ETH_TYPE_IPV4[15:8];
        hb[13] = ETH_TYPE_IPV4[7:0];
        hb[14] = 8'h45;
        hb[15] = 8'h00;
        hb[16] = tot_len[15:8];
        hb[17] = tot_len[7:0];
        hb[18] = ident[15:8];
        hb[19] = ident[7:0];
        hb[20] = 8'h40;
        hb[21] = 8'h00;
        hb[22] = TTL;
        hb[23] = IP_PROTO_UDP;
        hb[24] = csum_r[15:8];
        hb[25] = csum_r[7:0];
        for (int i = 0; i < 4; i++) begin
            hb[26 + i] = SRC_IP[8*(3-i) +: 8];
            hb[30 + i] = DST_IP[8*(3-i) +: 8];
        end
        hb[34] = SRC_PORT[15:8];
        hb[35] = SRC_PORT[7:0];
        hb[36] = DST_PORT[15:8];
        hb[37] = DST_PORT[7:0];
        hb[38] = udp_len[15:8];
        hb[39] = udp_len[7:0];
        for (int w = 0; w < HDR_WORDS; w++) begin
            hw[w] = {hb[4*w+3], hb[4*w+2], hb[4*w+1], hb[4*w]};
        end
    end

    always_comb begin
        state_n            = state;
        err_c              = 1'b0;
        req_hs             = 1'b0;
        txc_hs             = 1'b0;
        txd_hs             = 1'b0;
        bus.tx_req_ready   = 1'b0;
        bus.data_tready    = 1'b0;
        bus.eth_txc_tvalid = 1'b0;
        bus.eth_txc_tdata  = '0;
        bus.eth_txc_tkeep  = '0;
        bus.eth_txc_tlast  = 1'b0;
        bus.eth_txd_tvalid = 1'b0;
        bus.eth_txd_tdata  = '0;
        bus.eth_txd_tkeep  = '0;
        bus.eth_txd_tlast  = 1'b0;
        case (state)
            ST_IDLE: begin
                bus.tx_req_ready = data_aresetn;
                req_hs           = bus.tx_req_valid & data_aresetn;
                if (req_hs) begin
                    if (len_valid(bus.tx_payload_len)) state_n = ST_CTRL;
                    else                               err_c   = 1'b1;
                end
            end
            ST_CTRL: begin
                bus.eth_txc_tvalid = 1'b1;
                bus.eth_txc_tdata  = (cnt == 9'd0) ? TXC_FLAG_WORD : 32'h0;
                bus.eth_txc_tkeep  = 4'hF;
                bus.eth_txc_tlast  = (cnt == 9'(TXC_WORDS - 1));
                txc_hs             = bus.eth_txc_tready;
                if (txc_hs && bus.eth_txc_tlast) state_n = ST_HDR;
            end
            ST_HDR: begin
                bus.eth_txd_tvalid = 1'b1;
                bus.eth_txd_tdata  = hw[cnt[3:0]];
                bus.eth_txd_tkeep  = 4'hF;
                txd_hs             = bus.eth_txd_tready;
                if (txd_hs && cnt == 9'(HDR_WORDS - 1)) state_n = ST_PAY;
            end
            ST_PAY: begin
                // Pass-through: the first word carries the zero UDP checksum below.
                bus.eth_txd_tvalid = bus.data_tvalid;
                bus.data_tready    = bus.eth_txd_tready;
                bus.eth_txd_tdata  = {bus.data_tdata[15:0], (cnt == 9'd0) ? 16'h0000 : hold};
                bus.eth_txd_tkeep  = 4'hF;
                txd_hs             = bus.data_tvalid & bus.eth_txd_tready;
                if (txd_hs) begin
                    err_c = (bus.data_tlast != pay_last);
                    if (pay_last) state_n = ST_TAIL;
                end
            end
            ST_TAIL: begin
                bus.eth_txd_tvalid = 1'b1;
                bus.eth_txd_tdata  = {16'h0000, hold};
                bus.eth_txd_tkeep  = 4'b0011;
                bus.eth_txd_tlast  = 1'b1;
                txd_hs             = bus.eth_txd_tready;
                if (txd_hs) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge data_aclk) begin
        if (!data_aresetn) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            len_r  <= '0;
            hold   <= '0;
            ident  <= '0;
            csum_r <= '0;
        end else begin
            state <= state_n;
            case (state)
                ST_IDLE: if (req_hs) begin
                    len_r <= bus.tx_payload_len;
                    cnt   <= '0;
                end
                ST_CTRL: begin
                    csum_r <= csum_c;
                    if (txc_hs) cnt <= bus.eth_txc_tlast ? 9'd0 : cnt + 9'd1;
                end
                ST_HDR: if (txd_hs) cnt <= (cnt == 9'(HDR_WORDS - 1)) ? 9'd0 : cnt + 9'd1;
                ST_PAY: if (txd_hs) begin
                    hold <= bus.data_tdata[31:16];
                    cnt  <= cnt + 9'd1;
                end
                ST_TAIL: if (txd_hs) ident <= ident + 16'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_udp_tx.sv
// Directed bench for eth_udp_tx: table of frame requests plus hand sequences
// for early tlast and reset in the middle of a payload.
`timescale 1ns/1ps
module tb_eth_udp_tx;
  import eth_pkg::*;

  typedef struct {
    int          len;
    logic        stall;
    int          exp_errs;
    logic [15:0] exp_ident;
    logic [15:0] exp_csum;
    logic [15:0] exp_totlen;
    logic [15:0] exp_udplen;
    logic [31:0] exp_w10;
    logic [31:0] exp_last;
    int          exp_beats;  // 0 marks a rejected request
  } vec_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  eth_udp_tx_if bus();
  tx_state_t dbg_state;

  eth_udp_tx dut (
    .data_aclk    (clk),
    .data_aresetn (rst_n),
    .bus          (bus),
    .dbg_state    (dbg_state)
  );

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // monitor
  int cyc = 0;
  int req_cyc = 0;
  int err_cnt = 0;
  int err_beat = -1;
  int stall_viol = 0;
  logic [36:0] txd_q[$];
  int txd_t[$];
  logic [32:0] txc_q[$];
  int txc_t[$];
  logic d_stalled = 1'b0;
  logic c_stalled = 1'b0;
  logic [36:0] d_prev = '0;
  logic [32:0] c_prev = '0;

  always @(negedge clk) begin
    logic [36:0] d_cur;
    logic [32:0] c_cur;
    cyc++;
    d_cur = {bus.eth_txd_tlast, bus.eth_txd_tkeep, bus.eth_txd_tdata};
    c_cur = {bus.eth_txc_tlast, bus.eth_txc_tdata};
    if (rst_n) begin
      if (bus.tx_req_valid && bus.tx_req_ready) req_cyc = cyc;
      if (bus.err) begin
        err_cnt++;
        err_beat = txd_q.size();
      end
      if (d_stalled && (!bus.eth_txd_tvalid || d_cur != d_prev)) stall_viol++;
      if (c_stalled && (!bus.eth_txc_tvalid || c_cur != c_prev)) stall_viol++;
      if (bus.eth_txd_tvalid && bus.eth_txd_tready) begin
        txd_q.push_back(d_cur);
        txd_t.push_back(cyc);
      end
      if (bus.eth_txc_tvalid && bus.eth_txc_tready) begin
        txc_q.push_back(c_cur);
        txc_t.push_back(cyc);
      end
      d_stalled = bus.eth_txd_tvalid && !bus.eth_txd_tready;
      c_stalled = bus.eth_txc_tvalid && !bus.eth_txc_tready;
      d_prev = d_cur;
      c_prev = c_cur;
    end else begin
      d_stalled = 1'b0;
      c_stalled = 1'b0;
    end
  end

  // sink readiness
  logic stall_mode = 1'b0;
  initial begin
    bus.eth_txd_tready = 1'b0;
    bus.eth_txc_tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (stall_mode) begin
        bus.eth_txd_tready = ($urandom_range(0, 3) != 0);
        bus.eth_txc_tready = ($urandom_range(0, 2) != 0);
      end else begin
        bus.eth_txd_tready = 1'b1;
        bus.eth_txc_tready = 1'b1;
      end
    end
  end

  // driver tasks (entered and left just after a rising edge)
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_req(input int len, output logic ok);
    bus.tx_req_valid = 1'b1;
    bus.tx_payload_len = 16'(len);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = bus.tx_req_ready;
      @(posedge clk);
    end
    #1;
    bus.tx_req_valid = 1'b0;
  endtask

  task automatic send_payload(input int len, input int early, input logic gaps, output logic ok);
    int n;
    logic got;
    n = len / 4;
    ok = 1'b1;
    for (int k = 0; k < n && ok; k++) begin
      if (gaps) begin
        bus.data_tvalid = 1'b0;
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
      end
      for (int b = 0; b < 4; b++) bus.data_tdata[8*b +: 8] = 8'((4*k + b) & 255);
      bus.data_tlast = (k == n - 1) || (k == early);
      bus.data_tvalid = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 2000 && !got; i++) begin
        @(negedge clk);
        got = bus.data_tready;
        @(posedge clk);
      end
      #1;
      if (!got) ok = 1'b0;
    end
    bus.data_tvalid = 1'b0;
    bus.data_tlast = 1'b0;
  endtask

  task automatic wait_beats(input int n, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(posedge clk);
      #1;
      ok = (txd_q.size() >= n);
    end
  endtask

  // scoreboard: expected frame bytes built from constants and the table
  function automatic logic [7:0] exp_byte(input int i, input vec_t v);
    logic [47:0] dmac;
    logic [47:0] smac;
    logic [31:0] sip;
    logic [31:0] dip;
    dmac = 48'h02_00_00_00_00_00;
    smac = 48'h01_00_00_00_00_00;
    sip = 32'hC0A8010A;
    dip = 32'hC0A80101;
    if (i < 6) return dmac[8*(5-i) +: 8];
    if (i < 12) return smac[8*(11-i) +: 8];
    if (i >= 26 && i < 30) return sip[8*(29-i) +: 8];
    if (i >= 30 && i < 34) return dip[8*(33-i) +: 8];
    case (i)
      12: return 8'h08;
      14: return 8'h45;
      16: return v.exp_totlen[15:8];
      17: return v.exp_totlen[7:0];
      18: return v.exp_ident[15:8];
      19: return v.exp_ident[7:0];
      20: return 8'h40;
      22: return 8'd64;
      23: return 8'h11;
      24: return v.exp_csum[15:8];
      25: return v.exp_csum[7:0];
      34: return 8'h13;
      35: return 8'h88;
      36: return 8'h13;
      37: return 8'h89;
      38: return v.exp_udplen[15:8];
      39: return v.exp_udplen[7:0];
      default: ;
    endcase
    if (i >= 42 && i < 42 + v.len) return 8'((i - 42) & 255);
    return 8'h00;
  endfunction

  logic [36:0] exp_q[$];

  task automatic clear_obs();
    txd_q.delete();
    txd_t.delete();
    txc_q.delete();
    txc_t.delete();
    err_cnt = 0;
    err_beat = -1;
    stall_viol = 0;
  endtask

  task automatic check_frame(input vec_t v);
    int bad;
    int gaps;
    logic [31:0] w4;
    logic [31:0] w6;
    logic [31:0] w9;
    check("txc_beats", txc_q.size(), 6);
    bad = 0;
    for (int i = 0; i < txc_q.size() && i < 6; i++) begin
      if (txc_q[i] != {(i == 5), (i == 0) ? 32'hA000_0000 : 32'h0}) bad++;
    end
    check("txc_words", bad, 0);
    exp_q.delete();
    for (int w = 0; w < v.exp_beats; w++) begin
      logic [31:0] d;
      for (int b = 0; b < 4; b++) d[8*b +: 8] = exp_byte(4*w + b, v);
      exp_q.push_back({(w == v.exp_beats - 1), (w == v.exp_beats - 1) ? 4'b0011 : 4'hF, d});
    end
    check("txd_beats", txd_q.size(), v.exp_beats);
    bad = 0;
    for (int w = 0; w < exp_q.size() && w < txd_q.size(); w++) begin
      if (txd_q[w] !== exp_q[w]) bad++;
    end
    check("txd_word_errs", bad, 0);
    if (txd_q.size() == v.exp_beats) begin
      w4 = txd_q[4][31:0];
      w6 = txd_q[6][31:0];
      w9 = txd_q[9][31:0];
      check("ip_csum", {w6[7:0], w6[15:8]}, v.exp_csum);
      check("ip_ident", {w4[23:16], w4[31:24]}, v.exp_ident);
      check("ip_totlen", {w4[7:0], w4[15:8]}, v.exp_totlen);
      check("udp_len", {w9[23:16], w9[31:24]}, v.exp_udplen);
      check("word10", txd_q[10][31:0], v.exp_w10);
      check("last_word", txd_q[v.exp_beats - 1][31:0], v.exp_last);
      check("last_keep", txd_q[v.exp_beats - 1][35:32], 4'b0011);
      if (!v.stall && txc_q.size() == 6) begin
        gaps = 0;
        for (int w = 1; w < txd_t.size(); w++) if (txd_t[w] != txd_t[w-1] + 1) gaps++;
        check("txc_latency", txc_t[0] - req_cyc, 1);
        check("txc_to_txd", txd_t[0] - txc_t[5], 1);
        check("txd_bubbles", gaps, 0);
      end
    end
    check("stall_stable", stall_viol, 0);
    check("err_count", err_cnt, v.exp_errs);
  endtask

  task automatic run_vec(input vec_t v, input int early);
    logic ok;
    clear_obs();
    stall_mode = v.stall;
    send_req(v.len, ok);
    check("req_accept", ok, 1);
    if (v.exp_beats == 0) begin
      wait_cycles(10);
      check("bad_len_err", err_cnt, 1);
      check("bad_len_txc", txc_q.size(), 0);
      check("bad_len_txd", txd_q.size(), 0);
    end else begin
      send_payload(v.len, early, v.stall, ok);
      check("payload_accept", ok, 1);
      wait_beats(v.exp_beats, ok);
      wait_cycles(2);
      check_frame(v);
    end
    stall_mode = 1'b0;
  endtask

  vec_t vecs[8];

  initial begin
    logic ok;
    vec_t v;
    bus.tx_req_valid = 1'b0;
    bus.tx_payload_len = '0;
    bus.data_tdata = '0;
    bus.data_tkeep = 4'hF;
    bus.data_tlast = 1'b0;
    bus.data_tvalid = 1'b0;

    vecs[0] = '{64,   1'b0, 0, 16'h0000, 16'hB735, 16'h005C, 16'h0048, 32'h0100_0000, 32'h0000_3F3E, 27};
    vecs[1] = '{64,   1'b0, 0, 16'h0001, 16'hB734, 16'h005C, 16'h0048, 32'h0100_0000, 32'h0000_3F3E, 27};
    vecs[2] = '{6,    1'b0, 1, 16'h0,    16'h0,    16'h0,    16'h0,    32'h0,         32'h0,         0};
    vecs[3] = '{1476, 1'b0, 1, 16'h0,    16'h0,    16'h0,    16'h0,    32'h0,         32'h0,         0};
    vecs[4] = '{0,    1'b0, 1, 16'h0,    16'h0,    16'h0,    16'h0,    32'h0,         32'h0,         0};
    vecs[5] = '{4,    1'b0, 0, 16'h0002, 16'hB76F, 16'h0020, 16'h000C, 32'h0100_0000, 32'h0000_0302, 12};
    vecs[6] = '{64,   1'b1, 0, 16'h0003, 16'hB732, 16'h005C, 16'h0048, 32'h0100_0000, 32'h0000_3F3E, 27};
    vecs[7] = '{1472, 1'b0, 0, 16'h0004, 16'hB1B1, 16'h05DC, 16'h05C8, 32'h0100_0000, 32'h0000_BFBE, 379};

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", bus.tx_req_ready, 0);
    check("rst_txc_valid", bus.eth_txc_tvalid, 0);
    check("rst_txd_valid", bus.eth_txd_tvalid, 0);
    check("rst_data_ready", bus.data_tready, 0);
    check("rst_err", bus.err, 0);
    check("rst_txd_data", {bus.eth_txd_tlast, bus.eth_txd_tkeep, bus.eth_txd_tdata}, 37'h0);
    check("rst_state", dbg_state, ST_IDLE);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("idle_req_ready", bus.tx_req_ready, 1);
    wait_cycles(1);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], -1);

    // early tlast on payload beat 3: error at that beat, frame still follows L
    v = '{64, 1'b0, 1, 16'h0005, 16'hB730, 16'h005C, 16'h0048, 32'h0100_0000, 32'h0000_3F3E, 27};
    run_vec(v, 3);
    check("early_last_beat", err_beat, 13);

    // reset in the middle of the payload
    clear_obs();
    send_req(64, ok);
    check("mid_req_accept", ok, 1);
    bus.data_tdata = 32'h1122_3344;
    bus.data_tlast = 1'b0;
    bus.data_tvalid = 1'b1;
    wait_beats(13, ok);
    check("mid_pay_reached", ok, 1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_txd_valid", bus.eth_txd_tvalid, 0);
    check("mid_rst_txc_valid", bus.eth_txc_tvalid, 0);
    check("mid_rst_data_ready", bus.data_tready, 0);
    check("mid_rst_req_ready", bus.tx_req_ready, 0);
    check("mid_rst_state", dbg_state, ST_IDLE);
    @(posedge clk);
    #1;
    bus.data_tvalid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_req_ready", bus.tx_req_ready, 1);
    wait_cycles(1);
    v = '{4, 1'b0, 0, 16'h0000, 16'hB771, 16'h0020, 16'h000C, 32'h0100_0000, 32'h0000_0302, 12};
    run_vec(v, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
